// File: rtl/adc_trig_disc.sv
`default_nettype none
// ============================================================================
// Module   : adc_trig_disc
// Brief    : Edge-qualified ADC threshold trigger with holdoff, latched trigger
//            sample and saturating trigger counter.
// Revision : 1.0
// ============================================================================
module adc_trig_disc #(
    parameter int P_DW = 12,
    parameter int P_HW = 8,
    parameter int P_CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [P_DW-1:0] adc_data,
    input  logic            adc_valid,
    input  logic [P_DW-1:0] thresh,
    input  logic            gt,
    input  logic            lt,
    input  logic            et,
    input  logic            trig_en,
    input  logic [P_HW-1:0] holdoff,
    input  logic            cnt_clr,
    output logic            trig,
    output logic [P_DW-1:0] trig_sample,
    output logic [P_CW-1:0] trig_cnt,
    output logic            armed
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_WAIT_LOW = 2'd1,
        ST_ARMED    = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    localparam logic [P_CW-1:0] C_CNT_MAX = '1;
    localparam logic [P_CW-1:0] C_CNT_ONE = P_CW'(1);
    localparam logic [P_HW-1:0] C_H_ONE   = P_HW'(1);

    state_t          state_q, state_d;
    logic [P_HW-1:0] hcnt_q, hcnt_d;
    logic [P_CW-1:0] cnt_q, cnt_d;
    logic [P_DW-1:0] sample_q;
    logic            trig_q;
    logic            armed_q;

    logic cond;
    logic hit;
    logic miss;
    logic fire;

    assign cond = (gt & (adc_data > thresh))
                | (lt & (adc_data < thresh))
                | (et & (adc_data == thresh));
    assign hit  = adc_valid & cond;
    assign miss = adc_valid & ~cond;
    // Disabling suppresses a trigger even when the hit lands in ARMED.
    assign fire = trig_en & (state_q == ST_ARMED) & hit;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        if (!trig_en) begin
            state_d = ST_DISARMED;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_WAIT_LOW;
                ST_WAIT_LOW: begin
                    if (miss) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (hit) begin
                        if (holdoff == '0) begin
                            state_d = ST_WAIT_LOW;
                        end else begin
                            state_d = ST_HOLDOFF;
                            hcnt_d  = holdoff - C_H_ONE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hcnt_q == '0) begin
                        state_d = ST_WAIT_LOW;
                    end else begin
                        hcnt_d = hcnt_q - C_H_ONE;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    // A clear coinciding with a trigger counts that trigger.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = fire ? C_CNT_ONE : '0;
        end else if (fire && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_DISARMED;
            hcnt_q   <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            trig_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            cnt_q   <= cnt_d;
            trig_q  <= fire;
            armed_q <= (state_d == ST_ARMED);
            if (fire) begin
                sample_q <= adc_data;
            end
        end
    end

    assign trig        = trig_q;
    assign trig_sample = sample_q;
    assign trig_cnt    = cnt_q;
    assign armed       = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_trig_disc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_trig_disc
// Brief    : Directed stimulus with a trigger scoreboard for adc_trig_disc.
// Revision : 1.0
// ============================================================================
module tb_adc_trig_disc;

    localparam int P_DW      = 12;
    localparam int P_HW      = 8;
    localparam int P_CW      = 10;
    localparam int C_CNT_MAX = (1 << P_CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [P_DW-1:0] adc_data;
    logic            adc_valid;
    logic [P_DW-1:0] thresh;
    logic            gt;
    logic            lt;
    logic            et;
    logic            trig_en;
    logic [P_HW-1:0] holdoff;
    logic            cnt_clr;
    logic            trig;
    logic [P_DW-1:0] trig_sample;
    logic [P_CW-1:0] trig_cnt;
    logic            armed;

    typedef struct {
        int cyc;
        int sample;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_total = 0;
    int   n_bad   = 0;
    int   exp_cnt = 0;

    adc_trig_disc #(
        .P_DW(P_DW),
        .P_HW(P_HW),
        .P_CW(P_CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .thresh     (thresh),
        .gt         (gt),
        .lt         (lt),
        .et         (et),
        .trig_en    (trig_en),
        .holdoff    (holdoff),
        .cnt_clr    (cnt_clr),
        .trig       (trig),
        .trig_sample(trig_sample),
        .trig_cnt   (trig_cnt),
        .armed      (armed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cyc %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Monitor: every trig pulse must match the oldest expected trigger.
    always @(negedge clk) begin
        if (trig === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_trig: got trig at cyc %0d sample=0x%0h, expected none",
                         cyc, trig_sample);
            end else begin
                mon_e = exp_q.pop_front();
                check("trig_cycle", cyc, mon_e.cyc);
                check("trig_sample", int'(trig_sample), mon_e.sample);
                check("trig_cnt_at_trig", int'(trig_cnt), mon_e.cnt);
            end
        end
    end

    // Drive one cycle of sample input; 'fire' marks a sample the bench expects to trigger.
    task automatic step(input logic v, input logic [P_DW-1:0] d, input bit fire);
        exp_t e;
        adc_valid = v;
        adc_data  = d;
        if (fire) begin
            if (cnt_clr)                  exp_cnt = 1;
            else if (exp_cnt < C_CNT_MAX) exp_cnt++;
            e.cyc    = cyc + 1;
            e.sample = int'(d);
            e.cnt    = exp_cnt;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; adc_data = '0; adc_valid = 1'b0; thresh = '0;
        gt = 1'b0; lt = 1'b0; et = 1'b0; trig_en = 1'b0; holdoff = '0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_trig", int'(trig), 0);
        check("rst_sample", int'(trig_sample), 0);
        check("rst_cnt", int'(trig_cnt), 0);
        check("rst_armed", int'(armed), 0);
        rst = 1'b0;

        // Basic trigger, gt only, no holdoff
        thresh = 12'h800; gt = 1'b1; holdoff = '0; trig_en = 1'b1;
        step(1'b0, 12'h000, 1'b0);
        step(1'b1, 12'h100, 1'b0);
        step(1'b1, 12'h100, 1'b0);
        step(1'b1, 12'h900, 1'b1);
        step(1'b1, 12'h900, 1'b0);
        step(1'b1, 12'h100, 1'b0);
        step(1'b1, 12'hA00, 1'b1);
        step(1'b0, 12'h000, 1'b0);
        check("basic_cnt", int'(trig_cnt), 2);
        check("basic_sample", int'(trig_sample), 12'hA00);
        check("basic_armed", int'(armed), 0);

        // Holdoff 5: hits during holdoff ignored, spacing H+2 = 7
        holdoff = 8'd5;
        step(1'b1, 12'h100, 1'b0);
        check("ho_armed", int'(armed), 1);
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 12'h900, 1'b1);
            step(1'b1, 12'h900, 1'b0);
            step(1'b1, 12'h100, 1'b0);
            step(1'b1, 12'h900, 1'b0);
            step(1'b1, 12'h900, 1'b0);
            step(1'b1, 12'h900, 1'b0);
            step(1'b1, 12'h100, 1'b0);
        end
        check("ho_rearmed", int'(armed), 1);
        holdoff = '0;

        // Enable edge with level already above threshold
        trig_en = 1'b0;
        step(1'b1, 12'h900, 1'b0);
        check("dis_armed", int'(armed), 0);
        trig_en = 1'b1;
        repeat (4) step(1'b1, 12'h900, 1'b0);
        check("en_waitlow", int'(armed), 0);
        step(1'b1, 12'h800, 1'b0);
        check("en_armed", int'(armed), 1);
        step(1'b1, 12'h900, 1'b1);
        step(1'b1, 12'h100, 1'b0);
        trig_en = 1'b0;
        step(1'b1, 12'h900, 1'b0);
        check("en_drop_armed", int'(armed), 0);
        trig_en = 1'b1;
        repeat (3) step(1'b1, 12'h900, 1'b0);

        // Compare selects
        gt = 1'b0; et = 1'b1; thresh = 12'h123;
        step(1'b1, 12'h122, 1'b0);
        step(1'b1, 12'h123, 1'b1);
        et = 1'b0; lt = 1'b1;
        step(1'b1, 12'h200, 1'b0);
        step(1'b1, 12'h050, 1'b1);
        gt = 1'b1; lt = 1'b1; et = 1'b1;
        repeat (16) step(1'b1, P_DW'($urandom_range(0, 4095)), 1'b0);
        check("all_sel_waitlow", int'(armed), 0);
        gt = 1'b0; lt = 1'b0; et = 1'b0;
        repeat (8) step(1'b1, P_DW'($urandom_range(0, 4095)), 1'b0);
        check("no_sel_armed", int'(armed), 1);

        // Invalid cycles cause no transitions
        gt = 1'b1; thresh = 12'h800;
        step(1'b0, 12'h900, 1'b0);
        step(1'b0, 12'h900, 1'b0);
        check("gap_armed", int'(armed), 1);
        step(1'b1, 12'h900, 1'b1);
        step(1'b0, 12'h100, 1'b0);
        step(1'b0, 12'h100, 1'b0);
        check("gap_waitlow", int'(armed), 0);
        step(1'b1, 12'h900, 1'b0);
        step(1'b1, 12'h100, 1'b0);
        step(1'b0, 12'h900, 1'b0);
        step(1'b1, 12'hB00, 1'b1);

        // Clear coincident with trigger, then clear alone
        step(1'b1, 12'h100, 1'b0);
        cnt_clr = 1'b1;
        step(1'b1, 12'h900, 1'b1);
        cnt_clr = 1'b0;
        step(1'b0, 12'h000, 1'b0);
        check("clr_with_trig", int'(trig_cnt), 1);
        cnt_clr = 1'b1;
        step(1'b0, 12'h000, 1'b0);
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check("clr_alone", int'(trig_cnt), 0);

        // Counter saturation
        for (int i = 0; i < C_CNT_MAX + 8; i++) begin
            step(1'b1, 12'h100, 1'b0);
            step(1'b1, 12'h900, 1'b1);
        end
        step(1'b0, 12'h000, 1'b0);
        check("cnt_saturated", int'(trig_cnt), C_CNT_MAX);

        // Reset during holdoff with hcnt=3
        holdoff = 8'd6;
        step(1'b1, 12'h100, 1'b0);
        step(1'b1, 12'h900, 1'b1);
        step(1'b1, 12'h900, 1'b0);
        step(1'b1, 12'h900, 1'b0);
        rst = 1'b1;
        step(1'b1, 12'h900, 1'b0);
        check("midho_trig", int'(trig), 0);
        check("midho_sample", int'(trig_sample), 0);
        check("midho_cnt", int'(trig_cnt), 0);
        check("midho_armed", int'(armed), 0);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (4) step(1'b1, 12'h900, 1'b0);
        check("post_rst_waitlow", int'(armed), 0);

        // Reset while the pulse is high
        holdoff = '0;
        step(1'b1, 12'h100, 1'b0);
        step(1'b1, 12'h900, 1'b1);
        rst = 1'b1;
        step(1'b1, 12'h900, 1'b0);
        check("midpulse_trig", int'(trig), 0);
        check("midpulse_cnt", int'(trig_cnt), 0);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (4) step(1'b1, 12'h900, 1'b0);

        repeat (3) step(1'b0, 12'h000, 1'b0);
        check("pending_trigs", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
